// File: rtl/mpu_sequencer.sv
// MPU command sequencer: loads operand matrices, runs the datapath, streams results.
// Optional MPU_SEQ_SHORT_DET_EN: det (op 5) streams only element 0.
module mpu_sequencer #(
  parameter int EXEC_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [7:0]   cmd_size,
  input  logic [7:0]   cmd_factor,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [2:0]   dp_operation,
  output logic [199:0] dp_matrix_a,
  output logic [199:0] dp_matrix_b,
  output logic [7:0]   dp_size,
  output logic [7:0]   dp_factor,
  input  logic [199:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         busy,
  output logic         cmd_error
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, STORE
  } state_t;

  localparam logic [4:0] LAST_ELEM = 5'd24;
  localparam logic [4:0] EXEC_LAST = 5'(EXEC_CYCLES - 1);

  state_t state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic [7:0]   size_q, size_d;
  logic [7:0]   factor_q, factor_d;
  logic [199:0] a_q, a_d;
  logic [199:0] b_q, b_d;
  logic [199:0] res_q, res_d;
  logic         err_q, err_d;

  logic [7:0] idx;
  logic       cmd_bad;
  logic       need_b;
  logic       cnt_last;
  logic       out_end;

  assign idx      = {cnt_q, 3'b000};
  assign cmd_bad  = (cmd_op == 3'd7) || (cmd_size == 8'd0) ||
                    (cmd_size > 8'd5);
  assign need_b   = (op_q == 3'd0) || (op_q == 3'd1) ||
                    (op_q == 3'd6);
  assign cnt_last = (cnt_q == LAST_ELEM);

`ifdef MPU_SEQ_SHORT_DET_EN
  assign out_end = cnt_last || (op_q == 3'd5);
`else
  assign out_end = cnt_last;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    size_d   = size_q;
    factor_d = factor_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            op_d     = cmd_op;
            size_d   = cmd_size;
            factor_d = cmd_factor;
            cnt_d    = '0;
            state_d  = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (in_valid) begin
          a_d[idx +: 8] = in_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = need_b ? LOAD_B : EXEC;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          b_d[idx +: 8] = in_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = EXEC;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      EXEC: begin
        // counter doubles as the execution timer
        if (cnt_q == EXEC_LAST) begin
          res_d   = dp_result;
          cnt_d   = '0;
          state_d = STORE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      STORE: begin
        if (out_ready) begin
          if (out_end) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      size_q   <= '0;
      factor_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      size_q   <= size_d;
      factor_q <= factor_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign in_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy         = (state_q != IDLE);
  assign cmd_error    = err_q;
  assign dp_operation = op_q;
  assign dp_size      = size_q;
  assign dp_factor    = factor_q;
  assign dp_matrix_a  = a_q;
  assign dp_matrix_b  = b_q;
  assign out_valid    = (state_q == STORE);
  assign out_data     = out_valid ? res_q[idx +: 8] : 8'd0;
  assign out_last     = out_valid && out_end;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Self-checking bench for mpu_sequencer with a behavioural datapath stub.
// Define MPU_SEQ_SHORT_DET_EN to match a DUT built with the short-det option.
module tb_mpu_sequencer;

  localparam int EXEC_CYCLES = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [7:0]   cmd_size = '0;
  logic [7:0]   cmd_factor = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic [2:0]   dp_operation;
  logic [199:0] dp_matrix_a;
  logic [199:0] dp_matrix_b;
  logic [7:0]   dp_size;
  logic [7:0]   dp_factor;
  logic [199:0] dp_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic         cmd_error;

  mpu_sequencer #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_size(cmd_size), .cmd_factor(cmd_factor),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_operation(dp_operation), .dp_matrix_a(dp_matrix_a),
    .dp_matrix_b(dp_matrix_b), .dp_size(dp_size),
    .dp_factor(dp_factor), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] elem_fn(input logic [2:0] op,
                                         input logic [7:0] f,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return 8'(a + b);
      3'd1:    return 8'(a - b);
      3'd2:    return 8'(a * f);
      3'd3:    return 8'(8'd0 - a);
      3'd5:    return a ^ 8'h5a;
      3'd6:    return 8'(a + {b[6:0], 1'b0});
      default: return a;
    endcase
  endfunction

  // Datapath stand-in: elementwise ops, transpose for op 4
  always_comb begin
    dp_result = '0;
    for (int k = 0; k < 25; k++) begin
      if (dp_operation == 3'd4)
        dp_result[8*k +: 8] = dp_matrix_a[8*((k%5)*5 + k/5) +: 8];
      else
        dp_result[8*k +: 8] = elem_fn(dp_operation, dp_factor,
                                      dp_matrix_a[8*k +: 8],
                                      dp_matrix_b[8*k +: 8]);
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] ta[25];
  logic [7:0] tbm[25];
  logic [7:0] last_a[25];
  logic [7:0] last_b[25];
  logic [7:0] expv[25];
  int         nexp;

  typedef struct {
    logic [2:0] op;
    logic [7:0] size;
    logic [7:0] factor;
    bit         legal;
    int         mode;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [199:0] act,
                     input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] pack(input logic [7:0] m[25]);
    logic [199:0] v;
    v = '0;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = m[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input bit which, input int n);
    int sent = 0;
    int cyc = 0;
    bit fire;
    while (sent < n && cyc < 300) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = which ? tbm[sent] : ta[sent];
      fire = in_valid && in_ready;
      tick();
      if (fire) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk(which ? "load_b_beats" : "load_a_beats", 200'(sent), 200'(n));
  endtask

  task automatic collect(input logic [2:0] op, input int mode);
    int idx = 0;
    int cyc = 0;
    int pc = 0;
    int exec_n = 0;
    bit exec_ok = 1'b1;
    bit done = 1'b0;
    bit hold = 1'b0;
    logic [7:0] prev = '0;
    logic [3:0] pat = 4'b1001;
    while (!done && cyc < 400) begin
      if (!out_valid && busy && !in_ready) begin
        exec_n++;
        if (dp_operation !== op) exec_ok = 1'b0;
      end
      // stray traffic that must be ignored while busy
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 8'($urandom);
      if (mode == 1) out_ready = pat[pc % 4];
      else           out_ready = $urandom_range(0, 1) == 1;
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op    = 3'($urandom_range(0, 6));
      cmd_size  = 8'd2;
      if (hold) chk("out_hold", 200'(out_data), 200'(prev));
      if (out_valid && out_ready) begin
        chk("out_data", 200'(out_data),
            200'((idx < 25) ? expv[idx] : 8'hxx));
        chk("out_last", 200'(out_last), 200'(idx == nexp - 1));
        if (out_last) begin
          done = 1'b1;
          cmd_valid = 1'b0;
        end
        idx++;
      end
      if (out_valid) pc++;
      hold = out_valid && !out_ready;
      prev = out_data;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    chk("out_count", 200'(idx), 200'(nexp));
    chk("exec_cycles", 200'(exec_n), 200'(EXEC_CYCLES));
    chk("exec_op_stable", 200'(exec_ok), 200'(1));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] size,
                         input logic [7:0] factor, input bit legal,
                         input int mode);
    bit nb;
    cmd_op = op;
    cmd_size = size;
    cmd_factor = factor;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (!legal) begin
      chk("cmd_error_rise", 200'(cmd_error), 200'(1));
      chk("busy_rej", 200'(busy), 200'(0));
      chk("in_ready_rej", 200'(in_ready), 200'(0));
      tick();
      chk("cmd_error_fall", 200'(cmd_error), 200'(0));
      chk("busy_rej2", 200'(busy), 200'(0));
      chk("in_ready_rej2", 200'(in_ready), 200'(0));
      return;
    end
    chk("accept_busy", 200'(busy), 200'(1));
    chk("accept_cmd_ready", 200'(cmd_ready), 200'(0));
    chk("dp_operation", 200'(dp_operation), 200'(op));
    chk("dp_size", 200'(dp_size), 200'(size));
    chk("dp_factor", 200'(dp_factor), 200'(factor));
    nb = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
    load(1'b0, 25);
    last_a = ta;
    if (nb) begin
      chk("b_phase_in_ready", 200'(in_ready), 200'(1));
      load(1'b1, 25);
      last_b = tbm;
    end
    chk("after_load_in_ready", 200'(in_ready), 200'(0));
    for (int k = 0; k < 25; k++) begin
      if (op == 3'd4) expv[k] = last_a[(k%5)*5 + k/5];
      else expv[k] = elem_fn(op, factor, last_a[k], last_b[k]);
    end
    nexp = 25;
`ifdef MPU_SEQ_SHORT_DET_EN
    if (op == 3'd5) nexp = 1;
`endif
    collect(op, mode);
    chk("done_cmd_ready", 200'(cmd_ready), 200'(1));
    chk("done_busy", 200'(busy), 200'(0));
    chk("retain_a", dp_matrix_a, pack(last_a));
    chk("retain_b", dp_matrix_b, pack(last_b));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 200'(busy), 200'(0));
    chk({tag, "_cmd_ready"}, 200'(cmd_ready), 200'(1));
    chk({tag, "_in_ready"}, 200'(in_ready), 200'(0));
    chk({tag, "_out_valid"}, 200'(out_valid), 200'(0));
    chk({tag, "_out_last"}, 200'(out_last), 200'(0));
    chk({tag, "_out_data"}, 200'(out_data), 200'(0));
    chk({tag, "_cmd_error"}, 200'(cmd_error), 200'(0));
    chk({tag, "_dp_ctl"}, 200'({dp_operation, dp_size, dp_factor}), 200'(0));
    chk({tag, "_dp_a"}, dp_matrix_a, 200'(0));
    chk({tag, "_dp_b"}, dp_matrix_b, 200'(0));
  endtask

  task automatic rand_data();
    for (int k = 0; k < 25; k++) begin
      ta[k]  = 8'($urandom);
      tbm[k] = 8'($urandom);
    end
  endtask

  initial begin
    vecs[0]  = '{op: 3'd0, size: 8'd2, factor: 8'd0, legal: 1'b1, mode: 0};
    vecs[1]  = '{op: 3'd7, size: 8'd3, factor: 8'd0, legal: 1'b0, mode: 0};
    vecs[2]  = '{op: 3'd0, size: 8'd0, factor: 8'd0, legal: 1'b0, mode: 0};
    vecs[3]  = '{op: 3'd0, size: 8'd6, factor: 8'd0, legal: 1'b0, mode: 0};
    vecs[4]  = '{op: 3'd3, size: 8'd5, factor: 8'd0, legal: 1'b1, mode: 0};
    vecs[5]  = '{op: 3'd1, size: 8'd5, factor: 8'd9, legal: 1'b1, mode: 1};
    vecs[6]  = '{op: 3'd2, size: 8'd3, factor: 8'd7, legal: 1'b1, mode: 0};
    vecs[7]  = '{op: 3'd4, size: 8'd4, factor: 8'd0, legal: 1'b1, mode: 0};
    vecs[8]  = '{op: 3'd5, size: 8'd1, factor: 8'd0, legal: 1'b1, mode: 0};
    vecs[9]  = '{op: 3'd6, size: 8'd2, factor: 8'd0, legal: 1'b1, mode: 1};
    vecs[10] = '{op: 3'd0, size: 8'd255, factor: 8'd0, legal: 1'b0, mode: 0};
    vecs[11] = '{op: 3'd5, size: 8'd5, factor: 8'd3, legal: 1'b1, mode: 1};
    for (int k = 0; k < 25; k++) begin
      last_a[k] = 8'd0;
      last_b[k] = 8'd0;
    end

    reset_n = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        for (int k = 0; k < 25; k++) begin
          ta[k]  = 8'd3;
          tbm[k] = 8'd4;
        end
      end else begin
        rand_data();
      end
      run_cmd(vecs[i].op, vecs[i].size, vecs[i].factor,
              vecs[i].legal, vecs[i].mode);
    end

    for (int i = 0; i < 6; i++) begin
      rand_data();
      run_cmd(3'($urandom_range(0, 6)), 8'($urandom_range(1, 5)),
              8'($urandom), 1'b1, i % 2);
    end

    // abort mid-way through the B load
    rand_data();
    cmd_op = 3'd0;
    cmd_size = 8'd3;
    cmd_factor = 8'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    load(1'b0, 25);
    load(1'b1, 10);
    reset_n = 1'b0;
    tick();
    check_reset_state("abort");
    reset_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      last_a[k] = 8'd0;
      last_b[k] = 8'd0;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_out", 200'(out_valid), 200'(0));
    end
    rand_data();
    run_cmd(3'd3, 8'd4, 8'd0, 1'b1, 0);
    rand_data();
    run_cmd(3'd0, 8'd5, 8'd0, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
